// File: rtl/cache_controller.sv
// Write-back cache sequencer: serves CPU hits, writes back dirty victims and refills lines
// from a handshaked main memory, one request at a time.
module cache_controller #(
   parameter int unsigned ADDR_BITS  = 32,
   parameter int unsigned WORD_BITS  = 32,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned INDEX_BITS = 4,
   localparam int unsigned WOFF_BITS = $clog2(LINE_WORDS),
   localparam int unsigned TAG_BITS  = ADDR_BITS - INDEX_BITS - WOFF_BITS - 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic                 cpu_inv,
   input  logic [ADDR_BITS-1:0] cpu_addr,
   input  logic [WORD_BITS-1:0] cpu_din,
   output logic [WORD_BITS-1:0] cpu_dout,
   output logic                 cpu_ack,
   output logic                 cpu_busy,
   output logic [ADDR_BITS-1:0] cache_addr,
   output logic                 cache_load,
   output logic                 cache_edit,
   output logic                 cache_invalid,
   output logic [WORD_BITS-1:0] cache_din,
   input  logic                 cache_hit,
   input  logic [WORD_BITS-1:0] cache_dout,
   input  logic                 cache_valid,
   input  logic                 cache_dirty,
   input  logic [TAG_BITS-1:0]  cache_tag,
   output logic                 mem_cs,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [WORD_BITS-1:0] mem_dout,
   input  logic [WORD_BITS-1:0] mem_din,
   input  logic                 mem_ack
);

   typedef enum logic [2:0] {
      StIdle,
      StCompare,
      StWback,
      StRefill,
      StInval,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [ADDR_BITS-1:0]  addr_q;
   logic                  we_q;
   logic                  inv_q;
   logic [WORD_BITS-1:0]  din_q;
   logic [TAG_BITS-1:0]   victim_tag_q;
   logic [WOFF_BITS-1:0]  cnt_q;
   logic [WORD_BITS-1:0]  cpu_dout_q;

   logic [INDEX_BITS-1:0] req_index;
   logic [TAG_BITS-1:0]   req_tag;
   logic [ADDR_BITS-1:0]  wb_addr;
   logic [ADDR_BITS-1:0]  rf_addr;
   logic                  cnt_last;

   assign req_index = addr_q[WOFF_BITS+2 +: INDEX_BITS];
   assign req_tag   = addr_q[ADDR_BITS-1 -: TAG_BITS];
   assign wb_addr   = {victim_tag_q, req_index, cnt_q, 2'b00};
   assign rf_addr   = {req_tag, req_index, cnt_q, 2'b00};
   assign cnt_last  = (cnt_q == WOFF_BITS'(LINE_WORDS - 1));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (cpu_req) state_d = StCompare;
         end
         StCompare: begin
            if (cache_hit) begin
               if (inv_q) state_d = cache_dirty ? StWback : StInval;
               else       state_d = StDone;
            end else if (inv_q) begin
               state_d = StDone;
            end else if (cache_valid && cache_dirty) begin
               state_d = StWback;
            end else begin
               state_d = StRefill;
            end
         end
         StWback: begin
            if (mem_ack && cnt_last) state_d = inv_q ? StInval : StRefill;
         end
         StRefill: begin
            if (mem_ack && cnt_last) state_d = StCompare;
         end
         StInval: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic; every strobe is zero outside its owning state, including during reset
   always_comb begin
      cpu_ack       = 1'b0;
      cache_addr    = '0;
      cache_load    = 1'b0;
      cache_edit    = 1'b0;
      cache_invalid = 1'b0;
      cache_din     = '0;
      mem_cs        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_dout      = '0;
      case (state_q)
         StCompare: begin
            cache_addr = addr_q;
            if (cache_hit && we_q && !inv_q) begin
               cache_edit = 1'b1;
               cache_din  = din_q;
            end
         end
         StWback: begin
            cache_addr = wb_addr;
            mem_cs     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = wb_addr;
            mem_dout   = cache_dout;
         end
         StRefill: begin
            cache_addr = rf_addr;
            mem_cs     = 1'b1;
            mem_addr   = rf_addr;
            if (mem_ack) begin
               cache_load = 1'b1;
               cache_din  = mem_din;
            end
         end
         StInval: begin
            cache_addr    = addr_q;
            cache_invalid = 1'b1;
         end
         StDone: cpu_ack = 1'b1;
         default: ;
      endcase
   end

   assign cpu_busy = (state_q != StIdle);
   assign cpu_dout = cpu_dout_q;

   // Request latch, victim tag, word counter and read-data register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q       <= '0;
         we_q         <= 1'b0;
         inv_q        <= 1'b0;
         din_q        <= '0;
         victim_tag_q <= '0;
         cnt_q        <= '0;
         cpu_dout_q   <= '0;
      end else begin
         if (state_q == StIdle && cpu_req) begin
            addr_q <= cpu_addr;
            we_q   <= cpu_we;
            inv_q  <= cpu_inv;
            din_q  <= cpu_din;
         end
         if (state_q == StCompare) begin
            cnt_q <= '0;
            if (cache_hit && !inv_q && !we_q) cpu_dout_q <= cache_dout;
            if (state_d == StWback) victim_tag_q <= cache_tag;
         end
         // Counter wraps to zero after the last word, ready for the next burst
         if ((state_q == StWback || state_q == StRefill) && mem_ack) begin
            cnt_q <= cnt_q + WOFF_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache array and a
// two-cycle-latency memory whose read data is 0x11111111 + address.
module tb_cache_controller;

   logic        clk;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_inv;
   logic [31:0] cpu_addr, cpu_din, cpu_dout;
   logic        cpu_ack, cpu_busy;
   logic [31:0] cache_addr, cache_din, cache_dout;
   logic        cache_load, cache_edit, cache_invalid;
   logic        cache_hit, cache_valid, cache_dirty;
   logic [23:0] cache_tag;
   logic        mem_cs, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_dout, mem_din;

   int n_assert = 0;
   int n_fail   = 0;

   cache_controller dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_inv      (cpu_inv),
      .cpu_addr     (cpu_addr),
      .cpu_din      (cpu_din),
      .cpu_dout     (cpu_dout),
      .cpu_ack      (cpu_ack),
      .cpu_busy     (cpu_busy),
      .cache_addr   (cache_addr),
      .cache_load   (cache_load),
      .cache_edit   (cache_edit),
      .cache_invalid(cache_invalid),
      .cache_din    (cache_din),
      .cache_hit    (cache_hit),
      .cache_dout   (cache_dout),
      .cache_valid  (cache_valid),
      .cache_dirty  (cache_dirty),
      .cache_tag    (cache_tag),
      .mem_cs       (mem_cs),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_dout     (mem_dout),
      .mem_din      (mem_din),
      .mem_ack      (mem_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cache array model: 16 lines x 4 words
   logic [31:0] cdata [16][4];
   logic        cval   [16];
   logic        cdirty [16];
   logic [23:0] ctag   [16];
   logic [3:0]  m_idx;
   logic [1:0]  m_w;
   logic [23:0] m_tag;
   int load_cnt = 0, edit_cnt = 0, inv_cnt = 0, cs_cnt = 0, excl_err = 0;

   always_comb begin
      m_idx       = cache_addr[7:4];
      m_w         = cache_addr[3:2];
      m_tag       = cache_addr[31:8];
      cache_hit   = cval[m_idx] && (ctag[m_idx] == m_tag);
      cache_dout  = cdata[m_idx][m_w];
      cache_valid = cval[m_idx];
      cache_dirty = cdirty[m_idx];
      cache_tag   = ctag[m_idx];
   end

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            cval[i]   <= 1'b0;
            cdirty[i] <= 1'b0;
            ctag[i]   <= '0;
            for (int j = 0; j < 4; j++) cdata[i][j] <= '0;
         end
      end else begin
         if (cache_load) begin
            cdata[m_idx][m_w] <= cache_din;
            cval[m_idx]       <= 1'b1;
            cdirty[m_idx]     <= 1'b0;
            ctag[m_idx]       <= m_tag;
            load_cnt          <= load_cnt + 1;
         end
         if (cache_edit) begin
            cdata[m_idx][m_w] <= cache_din;
            cdirty[m_idx]     <= 1'b1;
            edit_cnt          <= edit_cnt + 1;
         end
         if (cache_invalid) begin
            cval[m_idx] <= 1'b0;
            inv_cnt     <= inv_cnt + 1;
         end
         if (mem_cs) cs_cnt <= cs_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if ($countones({cache_load, cache_edit, cache_invalid}) > 1) excl_err <= excl_err + 1;
   end

   // Memory model: ack two cycles after cs, one word per ack, transaction log
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   logic        log_we   [$];
   int          wait_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_ack  <= 1'b0;
         mem_din  <= '0;
         wait_cnt <= 0;
      end else begin
         mem_ack <= 1'b0;
         if (mem_cs && !mem_ack) begin
            if (wait_cnt == 1) begin
               mem_ack  <= 1'b1;
               mem_din  <= 32'h1111_1111 + mem_addr;
               wait_cnt <= 0;
               log_addr.push_back(mem_addr);
               log_we.push_back(mem_we);
               log_data.push_back(mem_we ? mem_dout : 32'h1111_1111 + mem_addr);
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end else begin
            wait_cnt <= 0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Latency = edges from the sampling edge up to the edge that consumes cpu_ack
   task automatic do_req(input logic we, input logic inv, input logic [31:0] addr,
                         input logic [31:0] din, output int lat, output logic [31:0] dout);
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_we   = we;
      cpu_inv  = inv;
      cpu_addr = addr;
      cpu_din  = din;
      @(posedge clk);
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         lat++;
         if (cpu_ack) break;
      end
      if (!cpu_ack) lat = -1;
      dout = cpu_dout;
      @(posedge clk);
      #1 cpu_req = 1'b0;
   endtask

   function automatic logic others_zero();
      return |{cpu_ack, cache_addr, cache_load, cache_edit, cache_invalid, cache_din,
               mem_we, mem_addr, mem_dout};
   endfunction

   int          lat, base, ld0, ed0, iv0, cs0, acks;
   logic [31:0] dout;

   initial begin
      rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_inv = 1'b0;
      cpu_addr = '0; cpu_din = '0;

      // 1. Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", cpu_busy, 0);
      check("rst_mem_cs", mem_cs, 0);
      check("rst_dout", cpu_dout, 0);
      check("rst_others", others_zero(), 0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      check("post_rst_busy", cpu_busy, 0);

      // 2. Cold read miss of line 0
      base = log_addr.size(); ld0 = load_cnt;
      do_req(1'b0, 1'b0, 32'h0000_0000, '0, lat, dout);
      check("cold_latency", lat, 15);
      check("cold_dout", dout, 32'h1111_1111);
      check("cold_loads", load_cnt - ld0, 4);
      check("cold_mem_count", log_addr.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("cold_addr%0d", i), log_addr[base+i], 32'(i * 4));
         check($sformatf("cold_we%0d", i), log_we[base+i], 0);
      end

      // 3. Read hit
      cs0 = cs_cnt;
      do_req(1'b0, 1'b0, 32'h0000_0004, '0, lat, dout);
      check("hit_latency", lat, 2);
      check("hit_dout", dout, 32'h1111_1115);
      check("hit_no_mem", cs_cnt - cs0, 0);
      check("ack_pulse", cpu_ack, 0);

      // 4. Write hit then reread
      ed0 = edit_cnt; cs0 = cs_cnt;
      do_req(1'b1, 1'b0, 32'h0000_0008, 32'h2222_2222, lat, dout);
      check("write_latency", lat, 2);
      check("write_edits", edit_cnt - ed0, 1);
      check("write_no_mem", cs_cnt - cs0, 0);
      do_req(1'b0, 1'b0, 32'h0000_0008, '0, lat, dout);
      check("reread_dout", dout, 32'h2222_2222);

      // 5. Dirty conflict miss: write back line 0, refill tag 1
      base = log_addr.size(); ld0 = load_cnt;
      do_req(1'b0, 1'b0, 32'h0000_0108, '0, lat, dout);
      check("dirty_latency", lat, 27);
      check("dirty_dout", dout, 32'h1111_1219);
      check("dirty_loads", load_cnt - ld0, 4);
      check("dirty_mem_count", log_addr.size() - base, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("dirty_we%0d", i), log_we[base+i], (i < 4) ? 1 : 0);
         check($sformatf("dirty_addr%0d", i), log_addr[base+i],
               (i < 4) ? 32'(i * 4) : 32'(32'h100 + (i - 4) * 4));
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wb_data%0d", i), log_data[base+i],
               (i == 2) ? 32'h2222_2222 : 32'(32'h1111_1111 + i * 4));
      end

      // 6. Invalidate clean hit, then reset in the middle of the following refill
      iv0 = inv_cnt; cs0 = cs_cnt;
      do_req(1'b0, 1'b1, 32'h0000_0100, '0, lat, dout);
      check("inv_latency", lat, 3);
      check("inv_pulses", inv_cnt - iv0, 1);
      check("inv_no_mem", cs_cnt - cs0, 0);

      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_inv = 1'b0; cpu_addr = 32'h0000_0100;
      @(posedge clk);
      repeat (2) @(posedge clk);
      #2;
      check("refill_cs", mem_cs, 1);
      check("refill_we", mem_we, 0);
      check("refill_addr", mem_addr, 32'h0000_0100);
      rst = 1'b0;
      cpu_req = 1'b0;
      #1;
      check("async_mem_cs", mem_cs, 0);
      check("async_busy", cpu_busy, 0);
      check("async_dout", cpu_dout, 0);
      check("async_others", others_zero(), 0);
      acks = 0;
      repeat (3) begin
         @(negedge clk);
         if (cpu_ack) acks++;
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (cpu_ack) acks++;
      end
      check("no_ack_after_rst", acks, 0);
      check("post_rst_idle", cpu_busy, 0);

      // Fresh refill after reset starts at word 0
      base = log_addr.size();
      do_req(1'b0, 1'b0, 32'h0000_0100, '0, lat, dout);
      check("rerefill_latency", lat, 15);
      check("rerefill_dout", dout, 32'h1111_1211);
      check("rerefill_first_addr", log_addr[base], 32'h0000_0100);

      check("strobes_exclusive", excl_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
